l1_feast_layer: RTL and testbench
=================================

// Module: l1_feast_layer
// PURPOSE
//  Forward (inference) side of layer-1 training: 2 neurons x 8 input channels. Keeps a decaying
//  time surface per channel and a decaying trace per neuron, computes each neuron's level value
//  as the dot product of surface and weights, and fires a winner-take-all spike when threshold is
//  met. Consumes weights/thresholds from the L1 trainer; feeds it spikes, surfaces, levels, traces.
// PARAMETERS
//  P_WIDTH     9     surface, trace and weight width
//  P_LV_W      21    level/threshold width (= 2*P_WIDTH+3)
//  P_DECAY_DIV 64    clocks per decay tick (>=2)
//  P_SPIKE_W   4     clocks o_spikeout is held high (>=1)
// PORTS
//  i_clk         in   1            sole clock, rising edge
//  i_rst_n       in   1            asynchronous active-low reset
//  i_event       in   8            [8:1] input event strobes, 1 clk each, any combination
//  i_weights     in   2*8*P_WIDTH  neuron n chan c at [P_WIDTH*(8*(n-1)+c-1) +: P_WIDTH]
//  i_thresholds  in   2*P_LV_W     neuron n at [P_LV_W*(n-1) +: P_LV_W]
//  o_spikeout    out  2            [2:1] winner spike, one-hot, P_SPIKE_W clks wide
//  o_ts          out  2*8*P_WIDTH  surface, same packing as i_weights (both halves identical)
//  o_tr          out  2*P_WIDTH    neuron traces, neuron 1 in low bits
//  o_lv          out  2*P_LV_W     last computed level values, neuron 1 in low bits
//  o_busy        out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs, surfaces, traces, levels, prescaler, pending flag = 0; state IDLE.
//  - Decay tick: prescaler counts 0..P_DECAY_DIV-1, tick on wrap. On tick every surface and trace
//    element decrements by 1, saturating at 0. Event on channel c same cycle as tick: ts[c]=max
//    (all ones); event wins. Spike same cycle as tick: trace=max; spike wins.
//  - Surfaces update on every event edge regardless of state.
//  - FSM IDLE->MAC->CMP->SPIKE->IDLE:
//    IDLE: any i_event bit (or pending flag) -> clear accumulators, ch idx=1, go MAC, clear pending.
//    MAC: 8 clocks; each clock acc[n] += ts[c]*w[n][c] for both neurons in parallel, unsigned,
//      full P_LV_W width (no overflow at defaults). Surfaces read live (post-event values).
//    CMP: 1 clock; o_lv <= acc; fire[n] = acc[n] >= thr[n]. Winner = larger acc among firing
//      neurons; tie -> neuron 1. Winner present: o_spikeout one-hot, trace[winner]=max, go SPIKE.
//      None: go IDLE, o_spikeout stays 0.
//    SPIKE: hold o_spikeout P_SPIKE_W clks total, then drive 0, go IDLE.
//  - Latency: event sampled at edge T -> o_lv valid and o_spikeout high after edge T+9.
//  - Events while busy set pending; one pending flag only (extra events coalesce); serviced on
//    the first IDLE clock after return.
//  - Weights/thresholds sampled live each MAC/CMP clock; upstream changes them only between
//    spikes, so no shadowing.
//  - Reset mid-operation: immediate clear to reset values; partial spike truncated.
// CONFIGURATION
//  L1_LAYER_LEAK_EXP_EN defined: decay tick applies x <= x - (x>>3) (exponential leak, reaches 0
//  only through floor) to surfaces and traces. Undefined: linear decrement by 1 as above.
// STRUCTURE
//  - l1_pkg: P_WIDTH, P_LV_W defaults, state enum (IDLE,MAC,CMP,SPIKE), packing index functions.
//  - Sub-module l1_decay_reg: one P_WIDTH register with set/tick/saturate (and leak option);
//    instantiated 8x for surfaces and 2x for traces. Top holds prescaler, FSM, MAC, WTA.
// TESTING (defaults, weights all 0x03f, thresholds 0x007fff)
//  - Event ch1 only -> lv1=lv2=511*63=0x7dc1 < thr: o_lv updated at T+9, no spike, o_busy low T+10.
//  - Events ch1+ch2 same clk -> lv=0xfb82 both, tie: o_spikeout=2'b01 for 4 clks, tr1=0x1ff.
//  - Neuron 2 weights 0x07f, event ch1 -> lv2=0xfd81 > thr, lv1 below: o_spikeout=2'b10.
//  - Event ch3, wait 64 clks idle -> ts[3]=0x1fe; event on tick clk -> ts=0x1ff; with
//    L1_LAYER_LEAK_EXP_EN after one tick ts[3]=0x1c0.
//  - Events at T and T+3 -> one pending recompute after first pass, exactly 2 level updates.
//  - Assert i_rst_n low during SPIKE -> o_spikeout, o_busy, o_tr, o_ts all 0 immediately.

Source files
------------

// File: rtl/l1_feast_layer_pkg.sv
// l1_feast_layer_pkg: shared widths, FSM state type and bus packing helpers
// for the layer-1 forward path.
package l1_feast_layer_pkg;
    localparam int P_WIDTH = 9;
    localparam int P_LV_W  = 2 * P_WIDTH + 3;
    localparam int N_NEUR  = 2;
    localparam int N_CHAN  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        CMP   = 2'd2,
        SPIKE = 2'd3
    } state_t;

    // Bit offset of neuron n (0-based), channel c (0-based) in weight/surface buses
    function automatic int w_idx(input int n, input int c);
        return P_WIDTH * (N_CHAN * n + c);
    endfunction

    // Bit offset of neuron n (0-based) in level/threshold buses
    function automatic int lv_idx(input int n);
        return P_LV_W * n;
    endfunction
endpackage

// File: rtl/l1_feast_layer_if.sv
// l1_feast_layer_if: event/weight inputs and spike/surface/level outputs of the
// layer-1 forward path. master = upstream trainer side, slave = the layer.
interface l1_feast_layer_if;
    import l1_feast_layer_pkg::*;

    logic [N_CHAN-1:0]                 i_event;
    logic [N_NEUR*N_CHAN*P_WIDTH-1:0]  i_weights;
    logic [N_NEUR*P_LV_W-1:0]          i_thresholds;
    logic [N_NEUR-1:0]                 o_spikeout;
    logic [N_NEUR*N_CHAN*P_WIDTH-1:0]  o_ts;
    logic [N_NEUR*P_WIDTH-1:0]         o_tr;
    logic [N_NEUR*P_LV_W-1:0]          o_lv;
    logic                              o_busy;

    modport master (
        output i_event, i_weights, i_thresholds,
        input  o_spikeout, o_ts, o_tr, o_lv, o_busy
    );

    modport slave (
        input  i_event, i_weights, i_thresholds,
        output o_spikeout, o_ts, o_tr, o_lv, o_busy
    );
endinterface

// File: rtl/l1_feast_layer_decay_reg.sv
// l1_decay_reg: one decaying register used for time surfaces and traces.
// set loads all ones and beats a same-cycle tick. Build option
// L1_LAYER_LEAK_EXP_EN switches the tick from linear decrement to x - (x>>3).
module l1_decay_reg
    import l1_feast_layer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               set,
    input  logic               tick,
    output logic [P_WIDTH-1:0] q
);
    logic [P_WIDTH-1:0] q_dec;

`ifdef L1_LAYER_LEAK_EXP_EN
    assign q_dec = q - (q >> 3);
`else
    assign q_dec = (q == '0) ? '0 : q - P_WIDTH'(1);
`endif

    // Load on set, otherwise decay on tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q <= '0;
        end else if (set) begin
            q <= '1;
        end else if (tick) begin
            q <= q_dec;
        end
    end
endmodule

// File: rtl/l1_feast_layer.sv
// l1_feast_layer: layer-1 forward path, 2 neurons x 8 channels. Time surfaces
// and neuron traces decay on a prescaled tick; each event triggers an 8-clock
// MAC of surface x weight, a threshold compare and a winner-take-all spike.
// Build option: L1_LAYER_LEAK_EXP_EN (exponential leak, see l1_decay_reg).
//
// state | meaning
// IDLE  | waiting for an event or a pending recompute
// MAC   | one channel per clock into both accumulators, 8 clocks
// CMP   | latch levels, threshold test, winner-take-all
// SPIKE | holding the winner spike for P_SPIKE_W clocks in total
module l1_feast_layer
    import l1_feast_layer_pkg::*;
#(
    parameter int P_DECAY_DIV = 64,
    parameter int P_SPIKE_W   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    l1_feast_layer_if.slave bus
);
    localparam int PRE_W = $clog2(P_DECAY_DIV);
    localparam int SPK_W = (P_SPIKE_W > 1) ? $clog2(P_SPIKE_W) : 1;

    state_t              state, state_nxt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [SPK_W-1:0]    spk_cnt;
    logic [2:0]          ch_idx;
    logic                pend;
    logic                ev_any;
    logic                start, mac_en, cmp_en, spk_en;
    logic [P_WIDTH-1:0]  ts [N_CHAN];
    logic [P_WIDTH-1:0]  tr [N_NEUR];
    logic [P_LV_W-1:0]   acc [N_NEUR];
    logic [P_LV_W-1:0]   lv [N_NEUR];
    logic [P_LV_W-1:0]   prod [N_NEUR];
    logic [P_LV_W-1:0]   thr [N_NEUR];
    logic [N_NEUR-1:0]   fire, win_oh, spk, tr_set;

    assign ev_any = |bus.i_event;
    assign tick   = (pre_cnt == PRE_W'(P_DECAY_DIV - 1));

    // Decay prescaler: counts 0..P_DECAY_DIV-1, tick on terminal count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Surfaces follow events in any state; both output halves carry the same surface
    for (genvar c = 0; c < N_CHAN; c++) begin : g_ts
        l1_decay_reg u_ts (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .set     (bus.i_event[c]),
            .tick    (tick),
            .q       (ts[c])
        );
        assign bus.o_ts[w_idx(0, c) +: P_WIDTH] = ts[c];
        assign bus.o_ts[w_idx(1, c) +: P_WIDTH] = ts[c];
    end

    // Traces are reloaded by the winner spike
    for (genvar n = 0; n < N_NEUR; n++) begin : g_nrn
        l1_decay_reg u_tr (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .set     (tr_set[n]),
            .tick    (tick),
            .q       (tr[n])
        );
        assign bus.o_tr[n*P_WIDTH +: P_WIDTH] = tr[n];
        assign bus.o_lv[lv_idx(n) +: P_LV_W]  = lv[n];
    end

    // Live product for the current channel, threshold test and winner select
    always_comb begin
        for (int n = 0; n < N_NEUR; n++) begin
            prod[n] = P_LV_W'(ts[ch_idx])
                    * P_LV_W'(bus.i_weights[w_idx(n, int'(ch_idx)) +: P_WIDTH]);
            thr[n]  = bus.i_thresholds[lv_idx(n) +: P_LV_W];
            fire[n] = (acc[n] >= thr[n]);
        end
        win_oh = '0;
        if (fire[0] && (!fire[1] || acc[0] >= acc[1])) begin
            win_oh = 2'b01;
        end else if (fire[1]) begin
            win_oh = 2'b10;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ev_any || pend) state_nxt = MAC;
            MAC:     if (ch_idx == 3'd7) state_nxt = CMP;
            CMP:     state_nxt = (win_oh != '0) ? SPIKE : IDLE;
            SPIKE:   if (spk_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        start  = 1'b0;
        mac_en = 1'b0;
        cmp_en = 1'b0;
        spk_en = 1'b0;
        case (state)
            IDLE:    start  = ev_any || pend;
            MAC:     mac_en = 1'b1;
            CMP:     cmp_en = 1'b1;
            SPIKE:   spk_en = 1'b1;
            default: ;
        endcase
    end

    assign tr_set         = {N_NEUR{cmp_en}} & win_oh;
    assign bus.o_spikeout = spk;
    assign bus.o_busy     = (state != IDLE);

    // Accumulators, channel index, level latch, spike hold and pending flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch_idx  <= '0;
            pend    <= 1'b0;
            spk     <= '0;
            spk_cnt <= '0;
            for (int n = 0; n < N_NEUR; n++) begin
                acc[n] <= '0;
                lv[n]  <= '0;
            end
        end else begin
            if (state == IDLE) begin
                pend <= 1'b0;
            end else if (ev_any) begin
                pend <= 1'b1;
            end
            if (start) begin
                ch_idx <= '0;
                for (int n = 0; n < N_NEUR; n++) acc[n] <= '0;
            end
            if (mac_en) begin
                ch_idx <= ch_idx + 3'd1;
                for (int n = 0; n < N_NEUR; n++) acc[n] <= acc[n] + prod[n];
            end
            if (cmp_en) begin
                for (int n = 0; n < N_NEUR; n++) lv[n] <= acc[n];
                spk     <= win_oh;
                spk_cnt <= SPK_W'(P_SPIKE_W - 1);
            end
            if (spk_en) begin
                if (spk_cnt == '0) begin
                    spk <= '0;
                end else begin
                    spk_cnt <= spk_cnt - SPK_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_l1_feast_layer.sv
// tb_l1_feast_layer: directed scenarios plus randomized events against a
// timeline reference model of the layer-1 forward path.
module tb_l1_feast_layer;
    localparam int W    = 9;
    localparam int LVW  = 21;
    localparam int NCH  = 8;
    localparam int NN   = 2;
    localparam int DIV  = 64;
    localparam int SPW  = 4;
    localparam int MAXV = 511;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    l1_feast_layer_if bus_if ();

    l1_feast_layer #(.P_DECAY_DIV(DIV), .P_SPIKE_W(SPW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_if)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    int w   [NN][NCH];
    int thr [NN];

    // reference model: surfaces, traces, levels, job timeline
    int         m_ts  [NCH];
    int         m_tr  [NN];
    int         m_lv  [NN];
    int         m_acc [NN];
    int         m_pre;
    int         m_phase;
    bit         m_pend;
    logic [1:0] m_spk;

    logic [41:0] prev_lv;
    int          lv_changes;
    int          spk_clks;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dec(input int x);
`ifdef L1_LAYER_LEAK_EXP_EN
        return x - (x >> 3);
`else
        return (x > 0) ? x - 1 : 0;
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_ts[c] = 0;
        for (int n = 0; n < NN; n++) begin
            m_tr[n] = 0; m_lv[n] = 0; m_acc[n] = 0;
        end
        m_pre = 0; m_phase = -1; m_pend = 0; m_spk = '0;
    endtask

    // One clock edge: phase counts edges since the triggering edge;
    // phases 1..8 accumulate channel phase-1, phase 9 compares,
    // spike stays high until phase 9+SPW.
    task automatic model_edge(input logic [7:0] ev);
        bit tick;
        int win;
        tick  = (m_pre == DIV - 1);
        m_pre = tick ? 0 : m_pre + 1;
        win   = -1;
        if (m_phase < 0) begin
            if (ev != 0 || m_pend) begin
                m_phase = 0; m_pend = 0;
                for (int n = 0; n < NN; n++) m_acc[n] = 0;
            end
        end else begin
            if (ev != 0) m_pend = 1;
            m_phase++;
            if (m_phase <= 8) begin
                for (int n = 0; n < NN; n++) m_acc[n] += m_ts[m_phase-1] * w[n][m_phase-1];
            end else if (m_phase == 9) begin
                for (int n = 0; n < NN; n++) m_lv[n] = m_acc[n];
                if (m_acc[0] >= thr[0] && (m_acc[1] < thr[1] || m_acc[0] >= m_acc[1])) win = 0;
                else if (m_acc[1] >= thr[1]) win = 1;
                if (win < 0) m_phase = -1;
                else m_spk = 2'(1 << win);
            end else if (m_phase == 9 + SPW) begin
                m_spk = '0; m_phase = -1;
            end
        end
        for (int c = 0; c < NCH; c++)
            m_ts[c] = ev[c] ? MAXV : (tick ? dec(m_ts[c]) : m_ts[c]);
        for (int n = 0; n < NN; n++)
            m_tr[n] = (win == n) ? MAXV : (tick ? dec(m_tr[n]) : m_tr[n]);
    endtask

    task automatic check_all();
        logic [143:0] e_ts;
        logic [17:0]  e_tr;
        logic [41:0]  e_lv;
        e_ts = '0; e_tr = '0; e_lv = '0;
        for (int n = 0; n < NN; n++) begin
            for (int c = 0; c < NCH; c++) e_ts[W*(NCH*n+c) +: W] = W'(m_ts[c]);
            e_tr[W*n +: W]     = W'(m_tr[n]);
            e_lv[LVW*n +: LVW] = LVW'(m_lv[n]);
        end
        chk("ts",    bus_if.o_ts, e_ts);
        chk("tr",    144'(bus_if.o_tr), 144'(e_tr));
        chk("lv",    144'(bus_if.o_lv), 144'(e_lv));
        chk("spike", 144'(bus_if.o_spikeout), 144'(m_spk));
        chk("busy",  144'(bus_if.o_busy), 144'(m_phase >= 0));
    endtask

    task automatic apply_cfg();
        for (int n = 0; n < NN; n++) begin
            for (int c = 0; c < NCH; c++) bus_if.i_weights[W*(NCH*n+c) +: W] = W'(w[n][c]);
            bus_if.i_thresholds[LVW*n +: LVW] = LVW'(thr[n]);
        end
    endtask

    task automatic set_uniform(input int w1, input int w2, input int t);
        for (int c = 0; c < NCH; c++) begin
            w[0][c] = w1; w[1][c] = w2;
        end
        thr[0] = t; thr[1] = t;
        apply_cfg();
    endtask

    task automatic step(input logic [7:0] ev);
        bus_if.i_event = ev;
        @(posedge i_clk);
        model_edge(ev);
        #1;
        bus_if.i_event = '0;
        if (bus_if.o_lv !== prev_lv) lv_changes++;
        prev_lv = bus_if.o_lv;
        check_all();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        bus_if.i_event = '0;
        #1;
        model_reset();
        check_all();
        prev_lv = '0;
        lv_changes = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        bus_if.i_event = '0;
        set_uniform(63, 63, 32'h7fff);
        do_reset();

        // single channel: below threshold, no spike
        step(8'h01);
        repeat (8) step(8'h00);
        chk("t1_busy_mac", 144'(bus_if.o_busy), 144'(1'b1));
        step(8'h00);
        chk("t1_lv", 144'(bus_if.o_lv), 144'({21'h007dc1, 21'h007dc1}));
        chk("t1_nospike", 144'(bus_if.o_spikeout), 144'(2'b00));
        step(8'h00);
        chk("t1_idle", 144'(bus_if.o_busy), 144'(1'b0));

        // two channels: tie goes to neuron 1
        do_reset();
        step(8'h03);
        repeat (9) step(8'h00);
        chk("t2_lv", 144'(bus_if.o_lv), 144'({21'h00fb82, 21'h00fb82}));
        chk("t2_tr", 144'(bus_if.o_tr), 144'({9'h000, 9'h1ff}));
        spk_clks = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_if.o_spikeout == 2'b01) spk_clks++;
            step(8'h00);
        end
        chk("t2_spike_width", 144'(spk_clks), 144'(SPW));

        // heavier neuron-2 weights: neuron 2 wins alone
        set_uniform(63, 127, 32'h7fff);
        do_reset();
        step(8'h01);
        repeat (9) step(8'h00);
        chk("t3_lv", 144'(bus_if.o_lv), 144'({21'h00fd81, 21'h007dc1}));
        chk("t3_spike", 144'(bus_if.o_spikeout), 144'(2'b10));

        // surface decay, event beating a tick
        set_uniform(63, 63, 32'h7fff);
        do_reset();
        step(8'h04);
        repeat (64) step(8'h00);
`ifdef L1_LAYER_LEAK_EXP_EN
        chk("t4_decay", 144'(bus_if.o_ts[W*2 +: W]), 144'(9'h1c0));
`else
        chk("t4_decay", 144'(bus_if.o_ts[W*2 +: W]), 144'(9'h1fe));
`endif
        for (int i = 0; i < DIV && m_pre != DIV - 1; i++) step(8'h00);
        step(8'h04);
        chk("t4_event_wins", 144'(bus_if.o_ts[W*2 +: W]), 144'(9'h1ff));
        chk("t4_event_wins_hi", 144'(bus_if.o_ts[W*10 +: W]), 144'(9'h1ff));

        // event during MAC -> one pending recompute, then reset mid-spike
        do_reset();
        step(8'h01);
        step(8'h00);
        step(8'h00);
        step(8'h02);
        repeat (18) step(8'h00);
        chk("t5_lv_updates", 144'(lv_changes), 144'(2));
        chk("t5_lv_final", 144'(bus_if.o_lv), 144'({21'h00fb82, 21'h00fb82}));
        chk("t6_in_spike", 144'(bus_if.o_spikeout), 144'(2'b01));
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_spike", 144'(bus_if.o_spikeout), 144'(0));
        chk("t6_rst_busy",  144'(bus_if.o_busy), 144'(0));
        chk("t6_rst_tr",    144'(bus_if.o_tr), 144'(0));
        chk("t6_rst_ts",    bus_if.o_ts, 144'(0));
        do_reset();

        // randomized weights, thresholds and event traffic
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < NN; n++) begin
                for (int c = 0; c < NCH; c++) w[n][c] = int'($urandom_range(0, MAXV));
                thr[n] = int'($urandom_range(0, 400000));
            end
            apply_cfg();
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 4) == 0) step(8'($urandom));
                else step(8'h00);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
